mult_fu: RTL and testbench

Pipelined integer multiply unit sitting directly downstream of the reservation station. It accepts at most one issued MULT-class instruction per cycle when it advertises ready, computes the RV32M product over a fixed number of stages, and presents the tagged result to the CDB arbiter with valid/ready backpressure. Its ready output is the `fu_ready.mult_*` bit the reservation station consults when selecting instructions to issue.

---
 rtl/mult_fu.sv | 170 +++++++++++++++++
 tb/tb_mult_fu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M integer multiply unit.
//
// An issued MULT-class instruction enters stage 0. The product is built from
// one partial-product chunk per stage, so the full 2*XLEN product is ready in
// the last stage. Each stage has its own valid bit. A stage holds its contents
// under backpressure and passes them on when the stage ahead can take them.
// Empty stages never block the stages behind them, so bubbles collapse.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid            issue request (honoured only while fu_ready=1)
//   in_rs1, in_rs2      source operands (XLEN)
//   in_func             0=MUL 1=MULH 2=MULHSU 3=MULHU
//   in_dest_tag         destination physical tag (TAG_W)
//   squash              flush every in-flight instruction on the next edge
//   fu_ready            unit can accept an instruction this cycle
//   out_valid           last stage holds a finished result
//   out_result          result value (XLEN)
//   out_dest_tag        result tag (TAG_W)
//   out_ready           CDB grant; result retires on out_valid && out_ready
module mult_fu #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [1:0]       in_func,
    input  logic [TAG_W-1:0] in_dest_tag,
    input  logic             squash,
    output logic             fu_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_dest_tag,
    input  logic             out_ready
);

    localparam int W    = 2 * XLEN;
    localparam int C    = W / STAGES;
    localparam int LAST = STAGES - 1;

    // Sign- or zero-extend an operand to the full product width.
    function automatic logic [W-1:0] extend_op(input logic [XLEN-1:0] op,
                                               input logic is_signed);
        extend_op = {{XLEN{is_signed & op[XLEN-1]}}, op};
    endfunction

    // rs1 is signed for everything except MULHU.
    function automatic logic rs1_signed(input logic [1:0] func);
        rs1_signed = (func != 2'd3);
    endfunction

    // rs2 is signed only for MUL and MULH.
    function automatic logic rs2_signed(input logic [1:0] func);
        rs2_signed = (func == 2'd0) || (func == 2'd1);
    endfunction

    // MUL returns the low half of the product; the MULH variants the high half.
    function automatic logic [XLEN-1:0] select_result(input logic [1:0] func,
                                                      input logic [W-1:0] prod);
        case (func)
            2'd0:    select_result = prod[XLEN-1:0];
            default: select_result = prod[W-1:XLEN];
        endcase
    endfunction

    // Stage state
    logic [STAGES-1:0] valid_r;
    logic [1:0]        func_r [STAGES];
    logic [TAG_W-1:0]  tag_r  [STAGES];
    logic [W-1:0]      m_r    [STAGES];
    logic [W-1:0]      r_r    [STAGES];
    logic [W-1:0]      p_r    [STAGES];
    logic [XLEN-1:0]   result_r;

    // open_s[k]: stage k will take new contents on the next edge (it is empty
    // or its contents move on). open_s[STAGES] is the CDB sink.
    logic [STAGES:0]   open_s;
    logic              accept_s;

    // What each stage would load on the next edge, chunk already applied.
    logic [STAGES-1:0] src_valid_s;
    logic [1:0]        src_func_s [STAGES];
    logic [TAG_W-1:0]  src_tag_s  [STAGES];
    logic [W-1:0]      src_m_s    [STAGES];
    logic [W-1:0]      src_r_s    [STAGES];
    logic [W-1:0]      src_p_s    [STAGES];
    logic [W-1:0]      nxt_m_s    [STAGES];
    logic [W-1:0]      nxt_r_s    [STAGES];
    logic [W-1:0]      nxt_p_s    [STAGES];

    // Backpressure chain, evaluated from the last stage toward stage 0.
    always_comb begin
        open_s         = {(STAGES+1){1'b0}};
        open_s[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            open_s[k] = !valid_r[k] || open_s[k+1];
        end
    end

    assign fu_ready = open_s[0];
    assign accept_s = in_valid && open_s[0] && !squash;

    // Per-stage source selection and one C-bit multiply-accumulate step.
    always_comb begin
        src_valid_s   = {STAGES{1'b0}};
        src_valid_s[0] = accept_s;
        src_func_s[0]  = in_func;
        src_tag_s[0]   = in_dest_tag;
        src_m_s[0]     = extend_op(in_rs1, rs1_signed(in_func));
        src_r_s[0]     = extend_op(in_rs2, rs2_signed(in_func));
        src_p_s[0]     = {W{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            src_valid_s[k] = valid_r[k-1];
            src_func_s[k]  = func_r[k-1];
            src_tag_s[k]   = tag_r[k-1];
            src_m_s[k]     = m_r[k-1];
            src_r_s[k]     = r_r[k-1];
            src_p_s[k]     = p_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nxt_p_s[k] = src_p_s[k] + src_m_s[k] * {{(W-C){1'b0}}, src_r_s[k][C-1:0]};
            nxt_m_s[k] = src_m_s[k] << C;
            nxt_r_s[k] = src_r_s[k] >> C;
        end
    end

    // Stage registers: squash clears, open stages load, blocked stages hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= {STAGES{1'b0}};
            result_r <= {XLEN{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                func_r[k] <= 2'b00;
                tag_r[k]  <= {TAG_W{1'b0}};
                m_r[k]    <= {W{1'b0}};
                r_r[k]    <= {W{1'b0}};
                p_r[k]    <= {W{1'b0}};
            end
        end else if (squash) begin
            valid_r <= {STAGES{1'b0}};
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (open_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        func_r[k] <= src_func_s[k];
                        tag_r[k]  <= src_tag_s[k];
                        m_r[k]    <= nxt_m_s[k];
                        r_r[k]    <= nxt_r_s[k];
                        p_r[k]    <= nxt_p_s[k];
                    end
                end
            end
            // The result half is selected as the last stage loads, so the
            // output comes straight from a register.
            if (open_s[LAST] && src_valid_s[LAST]) begin
                result_r <= select_result(src_func_s[LAST], nxt_p_s[LAST]);
            end
        end
    end

    assign out_valid    = valid_r[LAST];
    assign out_result   = result_r;
    assign out_dest_tag = tag_r[LAST];

endmodule

// File: tb/tb_mult_fu.sv
module tb_mult_fu;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 6;
    localparam int STAGES = 4;
    localparam int LAST   = STAGES - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [1:0]       in_func;
    logic [TAG_W-1:0] in_dest_tag;
    logic             squash;
    logic             fu_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_dest_tag;
    logic             out_ready;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // In-flight instructions, oldest first, each with its pipeline position.
    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               pos;
    } item_t;
    item_t q[$];

    mult_fu #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_func      (in_func),
        .in_dest_tag  (in_dest_tag),
        .squash       (squash),
        .fu_ready     (fu_ready),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_dest_tag (out_dest_tag),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RV32M reference using plain 64-bit arithmetic.
    function automatic logic [XLEN-1:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] f);
        longint x, y;
        logic [63:0] p;
        x = (f != 2'd3) ? longint'($signed(a)) : longint'({32'd0, a});
        y = (f <= 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        p = x * y;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // One cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] f, input logic [TAG_W-1:0] t, input logic sq,
                        input logic rdy, input logic use_exp, input logic [31:0] exp_val);
        item_t nq[$];
        item_t it;
        int    prev;
        logic  exp_ov, exp_rdy;
        in_valid = v; in_rs1 = a; in_rs2 = b; in_func = f; in_dest_tag = t;
        squash = sq; out_ready = rdy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].pos == LAST);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_result", out_result, q[0].res);
            chk("out_dest_tag", out_dest_tag, q[0].tag);
        end
        // Each instruction moves one position unless the one ahead still
        // sits directly in front of it; the oldest leaves when granted.
        prev = STAGES;
        for (int i = 0; i < q.size(); i++) begin
            it = q[i];
            if (it.pos == LAST) begin
                if (rdy) begin
                    prev = STAGES;
                end else begin
                    prev = LAST;
                    nq.push_back(it);
                end
            end else begin
                if (it.pos + 1 != prev) it.pos = it.pos + 1;
                prev = it.pos;
                nq.push_back(it);
            end
        end
        exp_rdy = 1'b1;
        foreach (nq[i]) if (nq[i].pos == 0) exp_rdy = 1'b0;
        chk("fu_ready", fu_ready, exp_rdy);
        if (sq) begin
            q.delete();
        end else begin
            q = nq;
            if (v && exp_rdy) begin
                it.res = use_exp ? exp_val : ref_mul(a, b, f);
                it.tag = t;
                it.pos = 0;
                q.push_back(it);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 32'd0, 2'd0, 6'd0, 1'b0, rdy, 1'b0, 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                         input logic [TAG_W-1:0] t, input logic rdy, input logic [31:0] e);
        step(1'b1, a, b, f, t, 1'b0, rdy, 1'b1, e);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_func = 2'd0;
        in_dest_tag = 6'd0; squash = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fu_ready", fu_ready, 1'b1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", out_dest_tag, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic MUL: 7 * -3
        issue(32'd7, 32'hFFFF_FFFD, 2'd0, 6'd5, 1'b1, 32'hFFFF_FFEB);
        repeat (5) idle(1'b1);

        // Signedness corners
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 6'd10, 1'b1, 32'h0000_0000);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 6'd11, 1'b1, 32'h8000_0000);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 6'd12, 1'b1, 32'h7FFF_FFFF);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 6'd13, 1'b1, 32'h8000_0000);
        repeat (5) idle(1'b1);

        // Backpressure: fill, fifth refused, then accepted on release edge
        for (int i = 0; i < 5; i++)
            issue(32'd100 + i, 32'd3, 2'd0, 6'd20 + i, 1'b0, 32'd300 + 3 * i);
        issue(32'd104, 32'd3, 2'd0, 6'd24, 1'b1, 32'd312);
        repeat (7) idle(1'b1);

        // Bubble collapse
        issue(32'd9, 32'd9, 2'd0, 6'd30, 1'b1, 32'd81);
        idle(1'b1);
        issue(32'd5, 32'd6, 2'd0, 6'd31, 1'b1, 32'd30);
        repeat (3) idle(1'b0);
        for (int i = 0; i < 3; i++)
            issue(32'd2, 32'd2 + i, 2'd0, 6'd32 + i, 1'b0, 32'd4 + 2 * i);
        repeat (7) idle(1'b1);

        // Squash with two in flight and a simultaneous issue
        issue(32'd11, 32'd11, 2'd0, 6'd40, 1'b1, 32'd121);
        issue(32'd12, 32'd12, 2'd0, 6'd41, 1'b1, 32'd144);
        step(1'b1, 32'd13, 32'd13, 2'd0, 6'd42, 1'b1, 1'b1, 1'b1, 32'd169);
        repeat (6) idle(1'b1);

        // Reset mid-flight
        for (int i = 0; i < 3; i++)
            issue(32'd20 + i, 32'd2, 2'd0, 6'd50 + i, 1'b0, 32'd40 + 2 * i);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_fu_ready", fu_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_op(), rand_op(),
                 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 1'b0, 32'd0);
        end
        repeat (8) idle(1'b1);
        chk("drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
